// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared fetch-side types: PC width, controller state encoding and next-PC source selection.
package fetch_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRED    = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEQ      = 3'd0,
        PRED_TGT = 3'd1,
        FALLTHRU = 3'd2,
        RESOLVED = 3'd3,
        HOLD     = 3'd4
    } npc_src_e;

    // Resolved target beats fall-through, which beats a fresh prediction; stall only holds.
    function automatic npc_src_e select_npc_src(input logic adr_miss, input logic pred_miss,
                                                input logic accept, input logic stall);
        if (adr_miss)       return RESOLVED;
        else if (pred_miss) return FALLTHRU;
        else if (accept)    return PRED_TGT;
        else if (stall)     return HOLD;
        else                return SEQ;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch redirect bus: predictor/pipeline inputs towards the PC controller and its outputs.
interface pc_redirect_ctrl_if
    import fetch_pkg::*;
();
    logic            stall;
    logic            jump_pred;
    logic [PC_W-1:0] jump_pred_adr;
    logic            jump_pred_miss;
    logic            jump_pred_adr_miss;
    logic [PC_W-1:0] pcinc_evac;
    logic [PC_W-1:0] ALUres_mem;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcinc;
    logic            redirect;
    logic            flush_if;
    logic            flush_id;
    logic            pred_active;
    logic [PC_W-1:0] hit_cnt;
    logic [PC_W-1:0] miss_cnt;

    modport master (
        output stall, jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
               pcinc_evac, ALUres_mem,
        input  pc, pcinc, redirect, flush_if, flush_id, pred_active, hit_cnt, miss_cnt
    );

    modport slave (
        input  stall, jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
               pcinc_evac, ALUres_mem,
        output pc, pcinc, redirect, flush_if, flush_id, pred_active, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_value
);
    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc && (r_value != {WIDTH{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: picks the next fetch address, tracks in-flight predictions,
// drives IF/ID flushes and keeps hit/miss statistics for the jump predictor.
module pc_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 16'h0000,
    parameter int              PRED_DEPTH     = 2,
    parameter int              RECOVER_CYCLES = 1
) (
    input logic              clk,
    input logic              reset,
    pc_redirect_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_PRED    = PRED;
    localparam logic [1:0] S_RECOVER = RECOVER;

    localparam int CNT_MAX = (PRED_DEPTH > RECOVER_CYCLES) ? PRED_DEPTH : RECOVER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PRED_LAST = CNT_W'(PRED_DEPTH - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER_CYCLES - 1);

    logic [PC_W-1:0]  r_pc;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_miss;
    logic             w_accept;
    npc_src_e         w_src;
    logic [PC_W-1:0]  w_pc_next;
    logic [PC_W-1:0]  w_pcinc;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_hit_inc;
    logic             w_in_recover;

    assign w_miss       = bus.jump_pred_miss | bus.jump_pred_adr_miss;
    assign w_accept     = (r_state == S_IDLE) & bus.jump_pred & ~bus.stall & ~w_miss;
    assign w_src        = select_npc_src(bus.jump_pred_adr_miss, bus.jump_pred_miss,
                                         w_accept, bus.stall);
    assign w_pcinc      = r_pc + 1'b1;
    assign w_in_recover = (r_state == S_RECOVER);

    always_comb begin
        w_pc_next = w_pcinc;
        case (w_src)
            RESOLVED: w_pc_next = bus.ALUres_mem;
            FALLTHRU: w_pc_next = bus.pcinc_evac;
            PRED_TGT: w_pc_next = bus.jump_pred_adr;
            HOLD:     w_pc_next = r_pc;
            default:  w_pc_next = w_pcinc;
        endcase
    end

    // r_cnt is shared: it counts resolution cycles in PRED and window cycles in RECOVER.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hit_inc    = 1'b0;
        if (w_miss) begin
            w_state_next = S_RECOVER;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_next = S_PRED;
                        w_cnt_next   = '0;
                    end
                end
                S_PRED: begin
                    if (!bus.stall) begin
                        if (r_cnt == PRED_LAST) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                            w_hit_inc    = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == REC_LAST) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    sat_counter #(.WIDTH(PC_W)) u_hit_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_hit_inc),
        .i_clr   (1'b0),
        .o_value (bus.hit_cnt)
    );

    sat_counter #(.WIDTH(PC_W)) u_miss_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_miss),
        .i_clr   (1'b0),
        .o_value (bus.miss_cnt)
    );

    assign bus.pc          = r_pc;
    assign bus.pcinc       = w_pcinc;
    assign bus.redirect    = (w_src == RESOLVED) | (w_src == FALLTHRU) | (w_src == PRED_TGT);
    assign bus.flush_if    = bus.redirect | w_in_recover;
    assign bus.flush_id    = w_in_recover | w_miss;
    assign bus.pred_active = (r_state == S_PRED);
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-side consumer of the jump predictor's outputs. It owns the program counter register and selects the next fetch address from four sources: sequential, predicted target, mispredict fall-through, or resolved target. A small state machine tracks each in-flight prediction until it is confirmed or squashed, drives the pipeline flushes, and keeps saturating hit/miss statistics for the predictor.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded by reset.
- PRED_DEPTH, 2, cycles from prediction acceptance to resolution at MEM. Must match the predictor's two-stage shift register.
- RECOVER_CYCLES, 1, length of the flush window after a misprediction, range 1..3.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- stall  in  1  pipeline stall; holds the PC and the PRED counter.
- jump_pred  in  1  predictor asserts taken this cycle.
- jump_pred_adr  in  16  predicted target.
- jump_pred_miss  in  1  predicted taken, resolved not taken.
- jump_pred_adr_miss  in  1  taken with a wrong or absent prediction.
- pcinc_evac  in  16  saved fall-through address of the predicted branch.
- ALUres_mem  in  16  resolved jump target.
- pc  out  16  current fetch address.
- pcinc  out  16  pc+1, modulo 2^16.
- redirect  out  1  next PC is non-sequential.
- flush_if  out  1  squash the IF/ID register.
- flush_id  out  1  squash the ID/EX register.
- pred_active  out  1  state is PRED.
- hit_cnt  out  16  confirmed predictions, saturating.
- miss_cnt  out  16  recoveries, saturating.

## Operation
- Next-PC priority, highest first:
  1. jump_pred_adr_miss → ALUres_mem.
  2. jump_pred_miss → pcinc_evac.
  3. jump_pred accepted → jump_pred_adr.
  4. stall → pc (hold).
  5. otherwise → pcinc.
- Both miss inputs asserted together: item 1 wins. It counts as a single miss.
- jump_pred is accepted only in IDLE with stall=0. Otherwise it is ignored: no redirect, no state change.
- States:
  - IDLE → PRED on an accepted jump_pred; cnt←0.
  - IDLE → RECOVER on any miss. This covers a taken jump that had no prediction.
  - PRED: cnt increments each cycle when stall=0. A miss → RECOVER. When cnt==PRED_DEPTH-1 with no miss → IDLE and hit_cnt+1.
  - RECOVER: lasts RECOVER_CYCLES cycles, then → IDLE. Stall is ignored. A further miss inside RECOVER restarts the window and counts again.
- miss_cnt increments on each cycle a miss is taken.
- Both counters saturate at 16'hFFFF and never wrap.
- redirect = (priority 1, 2, or 3 selected), combinational.
- flush_if = redirect | (state==RECOVER).
- flush_id = (state==RECOVER) | (a miss this cycle).
- PC arithmetic is 16-bit unsigned. pc=16'hFFFF gives pcinc=16'h0000.

## Timing
- Reset (asynchronous) sets: pc=RESET_PC, state=IDLE, cnt=0, hit_cnt=0, miss_cnt=0. Consequently pred_active=0, redirect=0, flush_if=0, flush_id=0, given the inputs are low.
- Reset asserted mid-PRED or mid-RECOVER aborts that state immediately; no counter update.
- The PC register updates on the rising clock edge. A redirect is visible on pc one cycle after the event.
- redirect, flush_if and flush_id are combinational from the inputs and the state in the same cycle. The state-derived flush terms are registered.
- Miss-to-correct-fetch latency is 1 cycle. The flush window is the miss cycle plus RECOVER_CYCLES.
- A prediction resolves PRED_DEPTH non-stalled cycles after acceptance.

## Structure
- Shared package fetch_pkg holds:
  - PC_W = 16.
  - The state enum typedef (IDLE, PRED, RECOVER).
  - The next-PC source enum (SEQ, PRED_TGT, FALLTHRU, RESOLVED, HOLD).
- One sub-module, sat_counter (WIDTH param; ports: increment enable, synchronous clear, value), instantiated twice for hit_cnt and miss_cnt.

## Test plan
- Reset with RESET_PC=16'h0010 → pc=0010; after 3 idle cycles pc=0013 with no flushes.
- jump_pred=1, jump_pred_adr=16'h0040 at pc=0005, no miss in the next 2 cycles → pc=0040 next cycle, flush_if for 1 cycle, hit_cnt=1.
- Prediction accepted, then jump_pred_miss=1 with pcinc_evac=16'h0006 → pc=0006, flush_if and flush_id asserted for 2 cycles, miss_cnt=1, state returns to IDLE.
- jump_pred_adr_miss and jump_pred_miss both asserted, ALUres_mem=16'h0123 → pc=0123, miss_cnt increments by exactly 1.
- stall held high during PRED → pc holds and cnt is frozen; miss during stall still redirects to ALUres_mem.
- Preload miss_cnt to FFFF via repeated misses, then one more miss → miss_cnt stays FFFF; pc=FFFF with no events → pc=0000.
